// File: rtl/carga_pkg.sv
// Shared constants for the operand/opcode loader: button indices and default debounce length.
// Latency: n/a (constants only).
// Backpressure: n/a.
package carga_pkg;

    localparam int NBTN             = 3;
    localparam int BTN_A            = 0;
    localparam int BTN_B            = 1;
    localparam int BTN_OP           = 2;

    // 10 ms at 100 MHz
    localparam int DEBOUNCE_CNT_DEF = 1000000;

endpackage

// File: rtl/carga_entradas_if.sv
// Board-side bundle of the loader: raw buttons/switches in, latched ALU operands and flags out.
// Latency: n/a (wires only).
// Backpressure: none; outputs are plain registered levels and a one-cycle pulse.
interface carga_entradas_if #(
    parameter int NBITS  = 8,
    parameter int COD_OP = 6
);

    logic [2:0]        pulsador;
    logic [NBITS-1:0]  entrada;
    logic [NBITS-1:0]  operando_A;
    logic [NBITS-1:0]  operando_B;
    logic [COD_OP-1:0] cod_operacion;
    logic [2:0]        cargados;
    logic              listo;
    logic              actualizado;

    // Board / stimulus side
    modport master (
        output pulsador, entrada,
        input  operando_A, operando_B, cod_operacion, cargados, listo, actualizado
    );

    // Loader side
    modport slave (
        input  pulsador, entrada,
        output operando_A, operando_B, cod_operacion, cargados, listo, actualizado
    );

endinterface

// File: rtl/antirrebote.sv
// One button channel: 2-flop synchronizer, debouncer (CARGA_DEBOUNCE_EN), rising-edge detector.
// Latency: press held from edge k gives a one-cycle pulso after edge k+DEBOUNCE_CNT+1 (k+1 without debouncer).
// Backpressure: none; one pulse per accepted press, releases never pulse.
module antirrebote
    import carga_pkg::*;
#(
    parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic boton,
    output logic pulso
);

    logic [1:0] sync_q;
    logic       stable;
    logic       stable_prev_q;

    // Bring the asynchronous button into the clock domain
    always_ff @(posedge clk) begin
        if (reset) sync_q <= 2'b00;
        else       sync_q <= {sync_q[0], boton};
    end

`ifdef CARGA_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);

    logic          stable_q;
    logic [CW-1:0] cnt_q;

    // Accept a new level only after it has differed from stable for DEBOUNCE_CNT consecutive cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else if (sync_q[1] == stable_q) begin
            cnt_q    <= '0;
        end else if (cnt_q == CW'(DEBOUNCE_CNT - 1)) begin
            stable_q <= sync_q[1];
            cnt_q    <= '0;
        end else begin
            cnt_q    <= cnt_q + CW'(1);
        end
    end

    assign stable = stable_q;
`else
    // Clean-stimulus build: the synchronized level is taken as already stable
    logic unused_cnt;
    assign unused_cnt = (DEBOUNCE_CNT > 0);
    assign stable     = sync_q[1];
`endif

    // Remember the previous stable level for edge detection
    always_ff @(posedge clk) begin
        if (reset) stable_prev_q <= 1'b0;
        else       stable_prev_q <= stable;
    end

    assign pulso = stable & ~stable_prev_q;

endmodule

// File: rtl/carga_entradas.sv
// Operand/opcode loader for the ALU: each qualified button press latches the switch bus into A, B or opcode.
// Latency: register and cargados update at edge k+DEBOUNCE_CNT+2 after a press held from edge k; actualizado one cycle later.
// Backpressure: none; debouncer is included only when CARGA_DEBOUNCE_EN is defined.
module carga_entradas
    import carga_pkg::*;
#(
    parameter int NBITS        = 8,
    parameter int COD_OP       = 6,
    parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    carga_entradas_if.slave  bus
);

    logic [NBTN-1:0]   carga;

    logic [NBITS-1:0]  operando_A_q, operando_A_d;
    logic [NBITS-1:0]  operando_B_q, operando_B_d;
    logic [COD_OP-1:0] cod_operacion_q, cod_operacion_d;
    logic [NBTN-1:0]   cargados_q, cargados_d;
    logic              actualizado_q, actualizado_d;

    for (genvar g = 0; g < NBTN; g++) begin : g_canal
        antirrebote #(
            .DEBOUNCE_CNT (DEBOUNCE_CNT)
        ) u_antirrebote (
            .clk   (clk),
            .reset (reset),
            .boton (bus.pulsador[g]),
            .pulso (carga[g])
        );
    end

    // Strobes are independent: every strobed register takes the same switch value
    always_comb begin
        operando_A_d    = operando_A_q;
        operando_B_d    = operando_B_q;
        cod_operacion_d = cod_operacion_q;
        if (carga[BTN_A])  operando_A_d    = bus.entrada;
        if (carga[BTN_B])  operando_B_d    = bus.entrada;
        if (carga[BTN_OP]) cod_operacion_d = bus.entrada[COD_OP-1:0];
        cargados_d      = cargados_q | carga;
        actualizado_d   = |carga;
    end

    // Load registers and flags; reset wins over a coincident strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            operando_A_q    <= '0;
            operando_B_q    <= '0;
            cod_operacion_q <= '0;
            cargados_q      <= '0;
            actualizado_q   <= 1'b0;
        end else begin
            operando_A_q    <= operando_A_d;
            operando_B_q    <= operando_B_d;
            cod_operacion_q <= cod_operacion_d;
            cargados_q      <= cargados_d;
            actualizado_q   <= actualizado_d;
        end
    end

    assign bus.operando_A    = operando_A_q;
    assign bus.operando_B    = operando_B_q;
    assign bus.cod_operacion = cod_operacion_q;
    assign bus.cargados      = cargados_q;
    assign bus.listo         = &cargados_q;
    assign bus.actualizado   = actualizado_q;

endmodule

// File: doc/carga_entradas.md
# carga_entradas

Operand/opcode loader that sits directly upstream of the ALU in the board top level. It conditions the three push-buttons (`pulsador`), and on each qualified press latches the switch bus (`entrada`) into operand A, operand B or the operation code. The registered values drive the ALU's `operando_A`, `operando_B` and `cod_operacion` inputs directly.

## Interface
Parameters:
- `NBITS`, 8: switch bus and operand width.
- `COD_OP`, 6: opcode width; must satisfy COD_OP ≤ NBITS.
- `DEBOUNCE_CNT`, 1000000: consecutive stable cycles required to accept a button change (10 ms at 100 MHz); must be ≥ 1.

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `pulsador`  in  3: raw asynchronous buttons. Bit 0 loads A, bit 1 loads B, bit 2 loads the opcode.
- `entrada`  in  NBITS: raw switch bus.
- `operando_A`  out  NBITS: latched operand A.
- `operando_B`  out  NBITS: latched operand B.
- `cod_operacion`  out  COD_OP: latched opcode, taken from `entrada[COD_OP-1:0]`.
- `cargados`  out  3: sticky per-register "loaded since reset" flags, same bit order as `pulsador`.
- `listo`  out  1: AND of the three `cargados` bits.
- `actualizado`  out  1: one-cycle pulse in the cycle after any register is written.

## Operation
- Each `pulsador` bit passes through its own conditioning channel:
  - 2-flop synchronizer, then the debouncer, then a rising-edge detector.
  - The edge detector produces a one-cycle `carga[i]` strobe per accepted press.
- Debouncer:
  - Holds a `stable` state and a counter.
  - While the synchronized input differs from `stable`, the counter increments.
  - When the input matches `stable`, the counter clears.
  - When the counter reaches DEBOUNCE_CNT, `stable` takes the input value and the counter clears.
  - Counter width is $clog2(DEBOUNCE_CNT+1).
- Only press (0→1) events load; releases never load.
- Register loading on `carga[i]`:
  - `carga[0]` loads `operando_A` ← `entrada`.
  - `carga[1]` loads `operando_B` ← `entrada`.
  - `carga[2]` loads `cod_operacion` ← `entrada[COD_OP-1:0]`.
  - Each load also sets `cargados[i]`.
- `entrada` is sampled directly (no synchronizer); switches are static during a press by usage contract.
- Simultaneous strobes are independent: every strobed register loads the same `entrada` value in the same edge, and `actualizado` pulses once.
- Re-pressing a button overwrites its register. `cargados` stays set.
- Holding a button produces exactly one load. Bounce shorter than DEBOUNCE_CNT cycles produces none.

## Timing
- Reset values:
  - `operando_A`, `operando_B`, `cod_operacion`: 0.
  - `cargados`: 3'b000.
  - `listo`, `actualizado`: 0.
  - Synchronizers, debouncer `stable` and counters: 0.
- Load latency: with `pulsador[i]` held high from edge k, the target register and `cargados[i]` update at edge k+DEBOUNCE_CNT+2. `actualizado` is high for exactly the following cycle.
- `listo` is combinational from registered `cargados`, so it rises in the same cycle as the last `cargados` bit.
- Reset mid-debounce: counters clear. A button still held after reset must be re-qualified for the full DEBOUNCE_CNT and then loads once, because the rising edge is seen relative to reset `stable` = 0.
- Reset has priority over a coincident strobe.

## Configuration
- `CARGA_DEBOUNCE_EN` defined:
  - Debouncer compiled in as described.
- `CARGA_DEBOUNCE_EN` undefined:
  - Debouncer omitted and `stable` is the synchronizer output.
  - Load latency becomes edge k+2, i.e. DEBOUNCE_CNT is treated as 0; the parameter is accepted but unused.
  - Intended for simulation with clean stimulus.

## Structure
- Shared package `carga_pkg`:
  - Button index constants `BTN_A`=0, `BTN_B`=1, `BTN_OP`=2.
  - Default DEBOUNCE_CNT.
- One sub-module, `antirrebote`: synchronizer + debouncer + rising-edge detector for one bit, with output `pulso`. Instantiated three times via generate.
- Top level of the block contains only the load registers and flags.

## Test plan
All scenarios use DEBOUNCE_CNT=4 and `CARGA_DEBOUNCE_EN` defined.
- Reset, then idle 20 cycles -> all outputs 0, `listo`=0, no `actualizado` pulse.
- `entrada`=8'h3C, hold `pulsador[0]` from edge k -> `operando_A`=8'h3C and `cargados`=3'b001 at edge k+6; `actualizado` high 1 cycle; no further loads while held.
- `pulsador[1]` toggles every 2 cycles for 20 cycles, then holds high with `entrada`=8'hA5 -> no load during toggling; exactly one load of 8'hA5 into `operando_B` after the hold.
- Press buttons 1 and 2 in the same cycle with `entrada`=8'hFF -> `operando_B`=8'hFF, `cod_operacion`=6'h3F in the same edge; single `actualizado` pulse.
- Load A, B, opcode in sequence -> `listo` rises on the third load. Re-press A with 8'h01 -> `operando_A`=8'h01, `listo` stays 1.
- Assert `reset` while `pulsador[0]` is held at counter value 2, then keep holding -> outputs 0 after reset; A loads 6 edges after reset deasserts.
- Rebuild without the macro -> the scenario-2 load occurs at edge k+2.
